// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter shared types: FSM state, stat counter width,
// round-robin pointer advance helper.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int STAT_CNT_WIDTH = 16;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO write-port bundle for fifo_wr_arbiter.
// master: producers + FIFO model side; slave: the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            grant;
    logic                          fifo_w_en;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_full;
    logic                          busy;

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, grant, fifo_w_en, fifo_data_in, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, grant, fifo_w_en, fifo_data_in, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter_picker.sv
// rr_priority_picker: first valid requester searching up from
// rr_ptr_i with wrap. Ports: req_valid_i, rr_ptr_i -> winner_o, found_o.
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [PW-1:0]      rr_ptr_i,
    output logic [NUM_REQ-1:0] winner_o,
    output logic               found_o
);
    always_comb begin
        int idx;
        idx      = 0;
        winner_o = '0;
        found_o  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_i) + k) % NUM_REQ;
            if (!found_o && req_valid_i[idx]) begin
                winner_o[idx] = 1'b1;
                found_o       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locking arbiter for one FIFO write port.
// Ports: clk, rst (sync, active-high), bus (slave modport);
// beat_count only when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
`ifdef FIFO_ARB_STATS_EN
    output logic [NUM_REQ*STAT_CNT_WIDTH-1:0] beat_count,
`endif
    fifo_wr_arbiter_if.slave bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state_q, state_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] win_oh;
    logic               found;
    logic [PW-1:0]      win_idx;
    logic [PW-1:0]      sel_idx;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] ready;
    logic               xfer;
    logic               last;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .req_valid_i (bus.req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .winner_o    (win_oh),
        .found_o     (found)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) win_idx = PW'(i);
        end
    end

    // Outputs are forced quiet while rst is held.
    always_comb begin
        grant   = '0;
        sel_idx = owner_q;
        if (state_q == LOCKED) begin
            grant[owner_q] = 1'b1;
        end else begin
            grant   = win_oh;
            sel_idx = win_idx;
        end
        if (rst) grant = '0;
    end

    assign ready = grant & {NUM_REQ{~bus.fifo_full & ~rst}};
    assign xfer  = |(bus.req_valid & ready);
    assign last  = bus.req_last[sel_idx];

    assign bus.req_ready    = ready;
    assign bus.grant        = grant;
    assign bus.fifo_w_en    = xfer;
    assign bus.fifo_data_in = (|grant)
        ? bus.req_data[sel_idx*DATA_WIDTH +: DATA_WIDTH]
        : '0;
    assign bus.busy         = (state_q == LOCKED) & ~rst;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            unique case (state_q)
                IDLE: begin
                    if (last) begin
                        rr_ptr_d = PW'(rr_next(int'(win_idx), NUM_REQ));
                    end else begin
                        state_d = LOCKED;
                        owner_d = win_idx;
                    end
                end
                LOCKED: begin
                    if (last) begin
                        state_d  = IDLE;
                        rr_ptr_d = PW'(rr_next(int'(owner_q), NUM_REQ));
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_CNT_WIDTH-1:0] cnt_q [NUM_REQ];

    // Saturating per-requester count of accepted beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i] && ready[i] && cnt_q[i] != '1) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        beat_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            beat_count[i*STAT_CNT_WIDTH +: STAT_CNT_WIDTH] = cnt_q[i];
        end
    end
`endif

    logic unused_found;
    assign unused_found = found;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Table-driven bench for fifo_wr_arbiter with a FIFO-order
// scoreboard; stats checks when FIFO_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;
    logic clk;
    logic rst;
`ifdef FIFO_ARB_STATS_EN
    logic [63:0] beat_count;
`endif

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef FIFO_ARB_STATS_EN
        .beat_count (beat_count),
`endif
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        r;
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        logic        f;
        logic [3:0]  g;
        logic        w;
        logic [7:0]  o;
        logic        b;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] sb[$];
    int         total;
    int         bad;

    function automatic vec_t mk(
        input logic r, input logic [3:0] v, input logic [3:0] l,
        input logic [31:0] d, input logic f, input logic [3:0] g,
        input logic w, input logic [7:0] o, input logic b
    );
        vec_t t;
        t.r = r; t.v = v; t.l = l; t.d = d; t.f = f;
        t.g = g; t.w = w; t.o = o; t.b = b;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive after posedge, check combinational outputs at negedge.
    task automatic apply(input vec_t t, input int n);
        logic [7:0] e;
        rst           = t.r;
        bus.req_valid = t.v;
        bus.req_last  = t.l;
        bus.req_data  = t.d;
        bus.fifo_full = t.f;
        if (t.w) sb.push_back(t.o);
        @(negedge clk);
        chk($sformatf("grant[%0d]", n), 32'(bus.grant), 32'(t.g));
        chk($sformatf("ready[%0d]", n), 32'(bus.req_ready),
            (t.f || t.r) ? 32'd0 : 32'(t.g));
        chk($sformatf("w_en[%0d]", n), 32'(bus.fifo_w_en), 32'(t.w));
        chk($sformatf("data[%0d]", n), 32'(bus.fifo_data_in), 32'(t.o));
        chk($sformatf("busy[%0d]", n), 32'(bus.busy), 32'(t.b));
        if (bus.fifo_w_en) begin
            if (sb.size() == 0) begin
                chk($sformatf("sb_extra[%0d]", n), 32'(bus.fifo_data_in), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk($sformatf("sb_order[%0d]", n), 32'(bus.fifo_data_in), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        @(posedge clk);
        #1;

        // reset and idle
        tbl.push_back(mk(1, 4'hF, 4'hF, 32'h13121110, 0, 4'h0, 0, 8'h00, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 32'h0,        0, 4'h0, 0, 8'h00, 0));
        // single-beat round robin
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'h13121110, 0, 4'h1, 1, 8'h10, 0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'h13121110, 0, 4'h2, 1, 8'h11, 0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'h13121110, 0, 4'h4, 1, 8'h12, 0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'h13121110, 0, 4'h8, 1, 8'h13, 0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 32'h13121110, 0, 4'h1, 1, 8'h10, 0));
        // packet lock: req1 AA BB CC, req2 waiting
        tbl.push_back(mk(0, 4'h6, 4'h4, 32'h00DDAA00, 0, 4'h2, 1, 8'hAA, 0));
        tbl.push_back(mk(0, 4'h6, 4'h4, 32'h00DDBB00, 0, 4'h2, 1, 8'hBB, 1));
        tbl.push_back(mk(0, 4'h6, 4'h6, 32'h00DDCC00, 0, 4'h2, 1, 8'hCC, 1));
        tbl.push_back(mk(0, 4'h4, 4'h4, 32'h00DD0000, 0, 4'h4, 1, 8'hDD, 0));
        // full back-pressure mid-packet of req3
        tbl.push_back(mk(0, 4'h8, 4'h0, 32'h31000000, 0, 4'h8, 1, 8'h31, 0));
        tbl.push_back(mk(0, 4'h9, 4'h0, 32'h320000A0, 1, 4'h8, 0, 8'h32, 1));
        tbl.push_back(mk(0, 4'h9, 4'h0, 32'h320000A0, 1, 4'h8, 0, 8'h32, 1));
        tbl.push_back(mk(0, 4'h9, 4'h0, 32'h320000A0, 1, 4'h8, 0, 8'h32, 1));
        tbl.push_back(mk(0, 4'h9, 4'h8, 32'h320000A0, 0, 4'h8, 1, 8'h32, 1));
        tbl.push_back(mk(0, 4'h1, 4'h1, 32'h000000A0, 0, 4'h1, 1, 8'hA0, 0));
        // owner gap on req1
        tbl.push_back(mk(0, 4'h3, 4'h1, 32'h000051A0, 0, 4'h2, 1, 8'h51, 0));
        tbl.push_back(mk(0, 4'h1, 4'h1, 32'h000051A0, 0, 4'h2, 0, 8'h51, 1));
        tbl.push_back(mk(0, 4'h1, 4'h1, 32'h000051A0, 0, 4'h2, 0, 8'h51, 1));
        tbl.push_back(mk(0, 4'h3, 4'h3, 32'h000052A0, 0, 4'h2, 1, 8'h52, 1));
        tbl.push_back(mk(0, 4'h1, 4'h1, 32'h000000A0, 0, 4'h1, 1, 8'hA0, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 32'h0,        0, 4'h0, 0, 8'h00, 0));
        // full drops the same cycle valid is present
        tbl.push_back(mk(0, 4'h4, 4'h4, 32'h00770000, 1, 4'h4, 0, 8'h77, 0));
        tbl.push_back(mk(0, 4'h4, 4'h4, 32'h00770000, 0, 4'h4, 1, 8'h77, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // reset mid-packet while req3 is locked
        apply(mk(0, 4'h8, 4'h0, 32'h09000000, 0, 4'h8, 1, 8'h09, 0), 100);
        apply(mk(1, 4'h9, 4'h9, 32'h0A000001, 0, 4'h0, 0, 8'h00, 0), 101);
        apply(mk(0, 4'h9, 4'h9, 32'h0A000001, 0, 4'h1, 1, 8'h01, 0), 102);
        apply(mk(0, 4'h8, 4'h8, 32'h0A000001, 0, 4'h8, 1, 8'h0A, 0), 103);

`ifdef FIFO_ARB_STATS_EN
        apply(mk(1, 4'h0, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 0), 200);
        chk("cnt_rst", 32'(beat_count[47:32]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            apply(mk(0, 4'h4, 4'h4, 32'h00050000, 0, 4'h4, 1, 8'h05, 0), 201);
        end
        apply(mk(0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 0), 202);
        chk("cnt2", 32'(beat_count[47:32]), 32'd5);
        chk("cnt013", 32'({beat_count[63:48], beat_count[31:0]}), 32'd0);
        for (int i = 0; i < 65540; i++) begin
            apply(mk(0, 4'h1, 4'h1, 32'h00000001, 0, 4'h1, 1, 8'h01, 0), 203);
        end
        apply(mk(0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 0), 204);
        chk("cnt0_sat", 32'(beat_count[15:0]), 32'h0000FFFF);
        chk("cnt2_hold", 32'(beat_count[47:32]), 32'd5);
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
